// File: rtl/apb_timer_slave.sv
// APB slave timer: a prescaled 32-bit down-counter with periodic or one-shot reload
// and a sticky interrupt. The number of access-phase wait states is set by a parameter.
module apb_timer_slave #(
  parameter int unsigned ADDRWIDTH   = 16,
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMERINT
);

  localparam int unsigned WCW = 2;
  localparam int unsigned PSW = 8;

  logic [2:0]           r_ctrl;
  logic [DATAWIDTH-1:0] r_value;
  logic [DATAWIDTH-1:0] r_reload;
  logic                 r_int;
  logic [PSW-1:0]       r_prescale;
  logic [PSW-1:0]       r_pcnt;
  logic [WCW-1:0]       r_wcnt;
  logic                 r_timerint;

  logic                 w_access;
  logic                 w_done;
  logic                 w_wr;
  logic [11:0]          w_off;
  logic                 w_sel_ctrl, w_sel_value, w_sel_reload, w_sel_int, w_sel_pre, w_hit;
  logic [DATAWIDTH-1:0] w_rdata;
  logic                 w_tick;
  logic                 w_int_set;
  logic [2:0]           w_ctrl_nxt;
  logic [DATAWIDTH-1:0] w_value_nxt;
  logic [DATAWIDTH-1:0] w_reload_nxt;
  logic [PSW-1:0]       w_pre_nxt;
  logic [PSW-1:0]       w_pcnt_nxt;
  logic                 w_int_nxt;
  logic                 w_unused;

  assign w_unused = ^{PPROT, PADDR[1:0], PADDR[ADDRWIDTH-1:12]};

  function automatic logic [DATAWIDTH-1:0] f_merge(input logic [DATAWIDTH-1:0] old_v,
                                                   input logic [DATAWIDTH-1:0] new_v,
                                                   input logic [3:0]           strb);
    logic [DATAWIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Handshake: PREADY rises once the access phase has waited WAIT_STATES cycles
  assign w_access = PSEL & PENABLE;
  assign PREADY   = w_access & (r_wcnt == WCW'(WAIT_STATES));
  assign w_done   = PREADY;
  assign w_off    = {PADDR[11:2], 2'b00};

  always_comb begin
    w_sel_ctrl   = (w_off == 12'h000);
    w_sel_value  = (w_off == 12'h004);
    w_sel_reload = (w_off == 12'h008);
    w_sel_int    = (w_off == 12'h00C);
    w_sel_pre    = (w_off == 12'h010);
    w_hit        = w_sel_ctrl | w_sel_value | w_sel_reload | w_sel_int | w_sel_pre;
    w_rdata      = '0;
    if (w_sel_ctrl)   w_rdata = {29'b0, r_ctrl};
    if (w_sel_value)  w_rdata = r_value;
    if (w_sel_reload) w_rdata = r_reload;
    if (w_sel_int)    w_rdata = {31'b0, r_int};
    if (w_sel_pre)    w_rdata = {24'b0, r_prescale};
  end

  assign w_wr     = w_done & PWRITE & w_hit;
  assign PSLVERR  = w_done & ~w_hit;
  assign PRDATA   = (w_done & ~PWRITE & w_hit) ? w_rdata : '0;
  assign TIMERINT = r_timerint;

  // Prescaler, counter and interrupt next-state; APB writes override hardware updates
  always_comb begin
    w_tick       = r_ctrl[0] & (r_pcnt == r_prescale);
    w_int_set    = 1'b0;
    w_ctrl_nxt   = r_ctrl;
    w_value_nxt  = r_value;
    w_reload_nxt = r_reload;
    w_pre_nxt    = r_prescale;
    w_int_nxt    = r_int;
    w_pcnt_nxt   = r_pcnt + PSW'(1);
    if (!r_ctrl[0] || w_tick) w_pcnt_nxt = '0;

    if (w_tick) begin
      if (r_value != '0) begin
        w_value_nxt = r_value - DATAWIDTH'(1);
      end else begin
        w_int_set = 1'b1;
        if (r_ctrl[2]) w_ctrl_nxt[0] = 1'b0;
        else           w_value_nxt   = r_reload;
      end
    end

    if (w_wr && w_sel_ctrl && PSTRB[0])  w_ctrl_nxt   = PWDATA[2:0];
    if (w_wr && w_sel_value)             w_value_nxt  = f_merge(r_value, PWDATA, PSTRB);
    if (w_wr && w_sel_reload)            w_reload_nxt = f_merge(r_reload, PWDATA, PSTRB);
    if (w_wr && w_sel_pre && PSTRB[0])   w_pre_nxt    = PWDATA[7:0];
    if (w_wr && w_sel_int && PSTRB[0] && PWDATA[0]) w_int_nxt = 1'b0;
    if (w_int_set)                       w_int_nxt    = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl     <= '0;
      r_value    <= '0;
      r_reload   <= '0;
      r_int      <= 1'b0;
      r_prescale <= '0;
      r_pcnt     <= '0;
      r_wcnt     <= '0;
      r_timerint <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_value    <= w_value_nxt;
      r_reload   <= w_reload_nxt;
      r_int      <= w_int_nxt;
      r_prescale <= w_pre_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_timerint <= r_int & r_ctrl[1];
      if (!PSEL || w_done)
        r_wcnt <= '0;
      else if (w_access && (r_wcnt < WCW'(WAIT_STATES)))
        r_wcnt <= r_wcnt + WCW'(1);
    end
  end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- 32-bit APB slave timer that sits directly downstream of the AHB-to-APB bridge.
- Consumes the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT and returns PRDATA/PREADY/PSLVERR.
- Provides a prescaled down-counter with auto-reload or one-shot mode, a sticky interrupt status bit and a level interrupt output.
- Wait states are configurable so the bridge's PREADY stall path can be exercised.

Parameters:
- ADDRWIDTH, 16, APB address width; offset decode uses PADDR[11:0].
- DATAWIDTH, 32, APB data width; only 32 is supported.
- WAIT_STATES, 0, number of access-phase cycles with PREADY low (0..3).

Ports:
- PCLK  input  1  APB clock; all logic is on the rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PADDR  input  ADDRWIDTH  byte address; PADDR[1:0] ignored.
- PWRITE  input  1  1 = write.
- PWDATA  input  DATAWIDTH  write data.
- PSTRB  input  4  write byte strobes.
- PPROT  input  3  protection; accepted and ignored.
- PRDATA  output  DATAWIDTH  read data.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  error response.
- TIMERINT  output  1  interrupt = INTSTAT & CTRL.IRQEN.

Behaviour:
- Clocking and reset: one clock (PCLK); reset is synchronous, active-high (PRESET).
  - Reset clears every register: CTRL=0, VALUE=0, RELOAD=0, INTSTAT=0, PRESCALE=0, prescale count=0, wait count=0.
  - Reset values of outputs: PRDATA=0, PREADY=0 when idle, PSLVERR=0, TIMERINT=0.
  - A reset during a transfer aborts it with no register update.
- Register map (offset = PADDR[11:0] with bits [1:0] cleared):
  - 0x00 CTRL: [0] EN, [1] IRQEN, [2] ONESHOT; other bits read 0.
  - 0x04 VALUE: RW; a write loads the counter.
  - 0x08 RELOAD: RW.
  - 0x0C INTSTAT: [0] INT; write 1 to clear, write 0 has no effect.
  - 0x10 PRESCALE: [7:0]; upper bits read 0.
  - Any other offset is a decode error.
- APB handshake:
  - Setup phase is PSEL & !PENABLE; access phase is PSEL & PENABLE.
  - The wait counter increments during the access phase while it is below WAIT_STATES.
  - PREADY = access & (wcnt == WAIT_STATES), and is 0 outside the access phase.
  - The wait counter clears on completion or when PSEL falls.
  - With WAIT_STATES=0, PREADY=1 in the first access cycle.
- Write commit:
  - Occurs only on the cycle PSEL & PENABLE & PREADY & PWRITE.
  - PSTRB byte lanes apply to CTRL, VALUE, RELOAD and PRESCALE.
  - INTSTAT clear uses lane 0.
- Read data: PRDATA is driven combinationally when access & PREADY & !PWRITE, and is 0 otherwise.
- Decode error: PSLVERR=1 only on the completing cycle (PREADY=1). No register changes, and PRDATA=0.
- Prescaler: pcnt counts 0..PRESCALE while EN=1. A tick occurs when pcnt==PRESCALE, and pcnt then wraps to 0. PRESCALE=0 gives a tick every cycle. EN=0 holds pcnt at 0.
- Counter, on a tick with EN=1:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: INT is set. If ONESHOT=1, EN clears and VALUE stays 0. Otherwise VALUE loads RELOAD.
  - A RELOAD of 0 in periodic mode raises INT on every tick.
- Simultaneous events:
  - An APB write to VALUE wins over decrement/reload in the same cycle.
  - A hardware INT set wins over a software clear in the same cycle.
  - An APB write to CTRL wins over the one-shot EN auto-clear.
  - A write to PRESCALE does not reset pcnt; a pcnt greater than the new PRESCALE counts up and wraps at 8 bits.
- TIMERINT is registered from INTSTAT and IRQEN. It therefore asserts one cycle after INT sets with IRQEN=1.

Test Plan:
- Reset then read all five registers (WAIT_STATES=0) -> each returns 0x00000000, PREADY=1 in the first access cycle, PSLVERR=0.
- RELOAD=3, VALUE=3, PRESCALE=0, CTRL=0x3 -> VALUE reads 2,1,0 on successive ticks, then INT sets, VALUE=3; TIMERINT rises one cycle after INT; write 0x1 to 0x0C clears INT and TIMERINT.
- PRESCALE=4, VALUE=2, CTRL=0x5 (one-shot) -> one decrement every 5 cycles; INT after 15 cycles; EN reads 0; VALUE stays 0; no further INT.
- WAIT_STATES=2, read 0x08 holding 0xDEADBEEF -> PREADY low for 2 access cycles, high on the 3rd with PRDATA=0xDEADBEEF.
- Write 0x0000AAAA to 0x08 with PSTRB=0b0010 over RELOAD=0x11223344 -> RELOAD reads 0x1122AA44. Then access 0x14 -> PSLVERR=1 with PREADY, PRDATA=0, no register change.
- Software write-1-clear to INTSTAT in the same cycle as a hardware INT set -> INT remains 1. Assert PRESET mid-access -> all registers 0 next cycle, PREADY=0.
